m_outputmux: RTL and testbench
==============================

Name: m_outputmux

Overview:
- Write-direction counterpart of the input mux: takes one store request from the core and delivers it either to the narrow external data-output port or to the writable system registers (MIE, MSTATUS, MIP.msip).
- Serializes a 32-bit store into OWIDTH-wide Wishbone-style beats, skipping disabled byte lanes.
- Drives the bus handshake and holds the interrupt-enable state that the input mux reads back.

Parameters:
- OWIDTH, 8, external write-data width; legal values 8, 16, 32.
- MTIMETAP, 0, system registers exist only when MTIMETAP >= 14; otherwise every store goes to the external port.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  one-cycle store request, sampled only in IDLE.
- ADR_O  in  32  store address; bits 29:28 select the target.
- Dstore  in  32  store data, already lane-aligned.
- sel  in  4  byte-lane enables.
- ACK_I  in  1  external acknowledge, may be combinational on STB_O.
- CYC_O  out  1  bus cycle active.
- STB_O  out  1  beat strobe.
- WE_O  out  1  write enable, equal to STB_O.
- WDAT_O  out  OWIDTH  current beat data.
- SEL_O  out  OWIDTH/8  byte enables of the current beat.
- BEAT_O  out  2  index of the current beat (lane for 8, half for 16, 0 for 32).
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- sysregack  out  1  one-cycle pulse when a system register is written.
- mie, mpie, meie, mtie, msie, mtimeincie, mrinstretie, msip  out  1 each  registered system bits.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, beat counter 0. Reset asserted mid-transfer drops STB_O and CYC_O immediately, with no completion.
- States are IDLE, XFER and FIN.
- IDLE + req, system-register path (MTIMETAP >= 14 and ADR_O[29:28] != 0):
  - Register writes happen on that edge, with sysregack=1 for the following cycle; then go to FIN.
  - 01 = MIP: msip <= Dstore[3].
  - 10 = MIE: msie <= Dstore[3], mtie <= Dstore[7], meie <= Dstore[11], mtimeincie <= Dstore[16], mrinstretie <= Dstore[17].
  - 11 = MSTATUS: mie <= Dstore[3], mpie <= Dstore[7].
  - sel is ignored on this path.
- IDLE + req, external path:
  - Capture Dstore and sel. The beat count is 4 for OWIDTH=8, 2 for 16, 1 for 32.
  - Beat k is enabled when any sel bit in its lane group is 1.
  - With no enabled beat, go directly to FIN with no bus activity. Otherwise load the first enabled beat and go to XFER.
- XFER:
  - CYC_O=STB_O=WE_O=1; WDAT_O and SEL_O come from the current beat group.
  - On an edge with ACK_I=1, advance to the next enabled beat (STB_O stays high, so a zero-wait slave completes one beat per cycle). If no enabled beat remains, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- busy=1 from the edge that accepts req through the last XFER cycle.
- req while busy or in FIN is ignored, not queued.
- ACK_I outside XFER is ignored.
- Latency: req at edge 0 puts the first beat on the bus in cycle 1. An all-zero-wait 8-bit word store completes in 4 XFER cycles, with done in cycle 5. A system-register write has done in cycle 1.
- When MTIMETAP < 14: register outputs are tied to 0 and sysregack=0.

Test Plan:
- OWIDTH=8: req with Dstore=32'hA1B2C3D4, sel=4'hF, ACK_I tied 1 -> WDAT_O sequence D4, C3, B2, A1 on BEAT_O 0..3 in cycles 1-4; done in cycle 5 only.
- OWIDTH=8: sel=4'b1010 with ACK_I delayed 2 cycles per beat -> only beats 1 and 3 appear, each held stable until ACK_I, SEL_O=1 on each; busy high throughout.
- MTIMETAP=14: req with ADR_O[29:28]=2'b10, Dstore=32'h00030888 -> msie=mtie=meie=mtimeincie=mrinstretie=1, STB_O never asserted, sysregack and done pulse in cycle 1. Then ADR_O[29:28]=2'b11 with Dstore=0 -> mie=mpie=0 and MIE bits unchanged.
- sel=0 on the external path -> no STB_O, done in cycle 1. A second req issued while busy -> no effect and exactly one done.
- rst_n pulled low during beat 2 of a 4-beat store -> STB_O/CYC_O drop asynchronously, no done; a fresh req after release runs normally from beat 0.
- OWIDTH=16, sel=4'b0011, Dstore=32'h12345678 -> a single beat with WDAT_O=16'h5678 and SEL_O=2'b11.

Source files
------------

// File: rtl/m_outputmux.sv
// Store-side output mux: one core store goes either to the narrow external write port
// (split into OWIDTH-wide beats, skipping beats with no enabled lanes) or to the system registers.
module m_outputmux #(
  parameter int OWIDTH   = 8,
  parameter int MTIMETAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [31:0]         ADR_O,
  input  logic [31:0]         Dstore,
  input  logic [3:0]          sel,
  input  logic                ACK_I,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O,
  output logic [OWIDTH-1:0]   WDAT_O,
  output logic [OWIDTH/8-1:0] SEL_O,
  output logic [1:0]          BEAT_O,
  output logic                busy,
  output logic                done,
  output logic                sysregack,
  output logic                mie,
  output logic                mpie,
  output logic                meie,
  output logic                mtie,
  output logic                msie,
  output logic                mtimeincie,
  output logic                mrinstretie,
  output logic                msip
);

  localparam int         NB     = 32 / OWIDTH;
  localparam int         LW     = OWIDTH / 8;
  localparam logic [3:0] LMASK  = 4'((1 << LW) - 1);
  localparam bit         SYS_EN = (MTIMETAP >= 14);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_e;

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  sel_q, sel_d;
  logic        sys_wr;
  logic        sysack_q;
  logic [2:0]  nb;
  logic        mie_q, mpie_q, meie_q, mtie_q, msie_q, mtimeincie_q, mrinstretie_q, msip_q;

  // Returns {found, index} of the lowest enabled beat at or above 'from'.
  function automatic logic [2:0] find_beat(input logic [3:0] s, input int from);
    logic [2:0] r;
    r = '0;
    for (int k = 3; k >= 0; k--) begin
      if (k < NB && k >= from && ((s >> (k * LW)) & LMASK) != 4'b0) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    sel_d   = sel_q;
    sys_wr  = 1'b0;
    nb      = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (SYS_EN && ADR_O[29:28] != 2'b00) begin
            sys_wr  = 1'b1;
            state_d = FIN;
          end else begin
            data_d = Dstore;
            sel_d  = sel;
            nb     = find_beat(sel, 0);
            if (nb[2]) begin
              beat_d  = nb[1:0];
              state_d = XFER;
            end else begin
              beat_d  = 2'd0;
              state_d = FIN;
            end
          end
        end
      end
      XFER: begin
        if (ACK_I) begin
          nb = find_beat(sel_q, int'(beat_q) + 1);
          if (nb[2]) beat_d = nb[1:0];
          else       state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      data_q   <= '0;
      sel_q    <= '0;
      sysack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      sysack_q <= sys_wr;
    end
  end

  // sys_wr is constant 0 without system registers, so these flops stay at reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q <= 1'b0; mpie_q <= 1'b0; meie_q <= 1'b0; mtie_q <= 1'b0;
      msie_q <= 1'b0; mtimeincie_q <= 1'b0; mrinstretie_q <= 1'b0; msip_q <= 1'b0;
    end else if (sys_wr) begin
      case (ADR_O[29:28])
        2'b01: msip_q <= Dstore[3];
        2'b10: begin
          msie_q        <= Dstore[3];
          mtie_q        <= Dstore[7];
          meie_q        <= Dstore[11];
          mtimeincie_q  <= Dstore[16];
          mrinstretie_q <= Dstore[17];
        end
        2'b11: begin
          mie_q  <= Dstore[3];
          mpie_q <= Dstore[7];
        end
        default: ;
      endcase
    end
  end

  logic xfer;
  assign xfer   = (state_q == XFER);
  assign CYC_O  = xfer;
  assign STB_O  = xfer;
  assign WE_O   = xfer;
  assign WDAT_O = xfer ? OWIDTH'(data_q >> (int'(beat_q) * OWIDTH)) : '0;
  assign SEL_O  = xfer ? LW'(sel_q >> (int'(beat_q) * LW)) : '0;
  assign BEAT_O = xfer ? beat_q : 2'd0;
  assign busy   = xfer;
  assign done   = (state_q == FIN);

  assign sysregack   = sysack_q;
  assign mie         = mie_q;
  assign mpie        = mpie_q;
  assign meie        = meie_q;
  assign mtie        = mtie_q;
  assign msie        = msie_q;
  assign mtimeincie  = mtimeincie_q;
  assign mrinstretie = mrinstretie_q;
  assign msip        = msip_q;

  logic unused_adr;
  assign unused_adr = ^{ADR_O[31:30], ADR_O[27:0]};

endmodule

// File: tb/tb_m_outputmux.sv
// Directed bench: 8-bit port with system registers (u8) and a 16-bit port without them (u16).
module tb_m_outputmux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req8, req16;
  logic [31:0] adr, dstore;
  logic [3:0]  sel;
  logic        ack;

  logic        cyc8, stb8, we8, busy8, done8, sack8;
  logic [7:0]  wdat8;
  logic [0:0]  sel8;
  logic [1:0]  beat8;
  logic        mie8, mpie8, meie8, mtie8, msie8, mtinc8, mret8, msip8;

  logic        cyc16, stb16, we16, busy16, done16, sack16;
  logic [15:0] wdat16;
  logic [1:0]  sel16;
  logic [1:0]  beat16;
  logic        mie16, mpie16, meie16, mtie16, msie16, mtinc16, mret16, msip16;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  m_outputmux #(.OWIDTH(8), .MTIMETAP(14)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .ADR_O(adr), .Dstore(dstore), .sel(sel), .ACK_I(ack),
    .CYC_O(cyc8), .STB_O(stb8), .WE_O(we8), .WDAT_O(wdat8), .SEL_O(sel8), .BEAT_O(beat8),
    .busy(busy8), .done(done8), .sysregack(sack8), .mie(mie8), .mpie(mpie8), .meie(meie8),
    .mtie(mtie8), .msie(msie8), .mtimeincie(mtinc8), .mrinstretie(mret8), .msip(msip8));

  m_outputmux #(.OWIDTH(16), .MTIMETAP(0)) u16 (
    .clk(clk), .rst_n(rst_n), .req(req16), .ADR_O(adr), .Dstore(dstore), .sel(sel), .ACK_I(ack),
    .CYC_O(cyc16), .STB_O(stb16), .WE_O(we16), .WDAT_O(wdat16), .SEL_O(sel16), .BEAT_O(beat16),
    .busy(busy16), .done(done16), .sysregack(sack16), .mie(mie16), .mpie(mpie16), .meie(meie16),
    .mtie(mtie16), .msie(msie16), .mtimeincie(mtinc16), .mrinstretie(mret16), .msip(msip16));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pulse req on u8 across one rising edge; returns at the negedge of cycle 1.
  task automatic issue8(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = a; dstore = d; sel = s; req8 = 1'b1;
    @(negedge clk);
    req8 = 1'b0;
  endtask

  initial begin
    int dones;
    int beats;
    rst_n = 1'b0; req8 = 1'b0; req16 = 1'b0; adr = '0; dstore = '0; sel = '0; ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stb", {31'd0, stb8}, 32'd0);
    check("rst_cyc", {31'd0, cyc8}, 32'd0);
    check("rst_done_busy", {30'd0, done8, busy8}, 32'd0);
    check("rst_sysbits", {24'd0, mie8, mpie8, meie8, mtie8, msie8, mtinc8, mret8, msip8}, 32'd0);
    check("rst_u16", {29'd0, stb16, done16, busy16}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full word, zero-wait slave.
    ack = 1'b1;
    exp_q.push_back(32'hD4); exp_q.push_back(32'hC3);
    exp_q.push_back(32'hB2); exp_q.push_back(32'hA1);
    issue8(32'h0, 32'hA1B2C3D4, 4'hF);
    for (int k = 0; k < 4; k++) begin
      check("t1_stb", {29'd0, stb8, cyc8, we8}, 32'd7);
      check("t1_wdat", {24'd0, wdat8}, exp_q.pop_front());
      check("t1_beat", {30'd0, beat8}, k);
      check("t1_sel_busy_done", {29'd0, sel8, busy8, done8}, 32'b110);
      @(negedge clk);
    end
    check("t1_done", {30'd0, done8, stb8}, 32'b10);
    @(negedge clk);
    check("t1_done_clear", {31'd0, done8}, 32'd0);

    // Sparse lanes, two wait states per beat.
    ack = 1'b0;
    issue8(32'h0, 32'hA1B2C3D4, 4'b1010);
    for (int b = 1; b < 4; b += 2) begin
      for (int w = 0; w < 3; w++) begin
        check("t2_stb_busy", {30'd0, stb8, busy8}, 32'b11);
        check("t2_beat", {30'd0, beat8}, b);
        check("t2_wdat", {24'd0, wdat8}, (b == 1) ? 32'hC3 : 32'hA1);
        check("t2_sel", {31'd0, sel8}, 32'd1);
        ack = (w == 2);
        @(negedge clk);
        ack = 1'b0;
      end
    end
    check("t2_done", {29'd0, done8, stb8, busy8}, 32'b100);
    @(negedge clk);

    // System registers: MIE, then MSTATUS set/clear, then MIP.
    issue8(32'h2000_0000, 32'h0003_0888, 4'h0);
    check("t3_ack_done", {29'd0, sack8, done8, stb8}, 32'b110);
    check("t3_mie_bits", {24'd0, mie8, mpie8, meie8, mtie8, msie8, mtinc8, mret8, msip8}, 32'b0011_1110);
    @(negedge clk);
    check("t3_ack_clear", {30'd0, sack8, done8}, 32'd0);
    issue8(32'h3000_0000, 32'h0000_0088, 4'hF);
    check("t3_mstatus_set", {24'd0, mie8, mpie8, meie8, mtie8, msie8, mtinc8, mret8, msip8}, 32'b1111_1110);
    @(negedge clk);
    issue8(32'h3000_0000, 32'h0, 4'hF);
    check("t3_mstatus_clr", {24'd0, mie8, mpie8, meie8, mtie8, msie8, mtinc8, mret8, msip8}, 32'b0011_1110);
    check("t3_stb", {31'd0, stb8}, 32'd0);
    @(negedge clk);
    issue8(32'h1000_0000, 32'h0000_0008, 4'h0);
    check("t3_msip", {24'd0, mie8, mpie8, meie8, mtie8, msie8, mtinc8, mret8, msip8}, 32'b0011_1111);
    @(negedge clk);

    // No enabled lanes: straight to completion.
    issue8(32'h0, 32'hFFFF_FFFF, 4'h0);
    check("t4_empty", {29'd0, done8, stb8, busy8}, 32'b100);
    @(negedge clk);

    // Second req while busy must be dropped.
    ack = 1'b1;
    issue8(32'h0, 32'h4433_2211, 4'hF);
    dones = 0; beats = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin dstore = 32'hDEAD_BEEF; req8 = 1'b1; end
      else req8 = 1'b0;
      if (stb8) begin
        beats++;
        check("t4_wdat", {24'd0, wdat8}, 32'h11 * (beats));
      end
      if (done8) dones++;
      @(negedge clk);
    end
    req8 = 1'b0;
    check("t4_beats", beats, 32'd4);
    check("t4_dones", dones, 32'd1);

    // Reset in the middle of a 4-beat store.
    issue8(32'h0, 32'hA1B2C3D4, 4'hF);
    @(negedge clk); @(negedge clk);
    check("t5_beat2", {30'd0, beat8}, 32'd2);
    #2 rst_n = 1'b0;
    #1 check("t5_async_drop", {30'd0, stb8, cyc8}, 32'd0);
    @(negedge clk);
    check("t5_no_done", {30'd0, done8, busy8}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_done2", {30'd0, done8, stb8}, 32'd0);
    issue8(32'h0, 32'hA1B2C3D4, 4'hF);
    check("t5_restart", {22'd0, stb8, beat8, wdat8}, {22'd0, 1'b1, 2'd0, 8'hD4});
    repeat (4) @(negedge clk);
    check("t5_restart_done", {31'd0, done8}, 32'd1);

    // 16-bit port, single low half.
    adr = 32'h0; dstore = 32'h1234_5678; sel = 4'b0011; req16 = 1'b1;
    @(negedge clk);
    req16 = 1'b0;
    check("t6_stb", {31'd0, stb16}, 32'd1);
    check("t6_wdat", {16'd0, wdat16}, 32'h5678);
    check("t6_sel_beat", {28'd0, sel16, beat16}, 32'b1100);
    @(negedge clk);
    check("t6_done", {30'd0, done16, stb16}, 32'b10);
    check("t6_no_sys", {31'd0, sack16}, 32'd0);
    ack = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
